// File: rtl/pll_sup_pkg.sv
// Purpose : shared types and constants for the PLL lock supervisor.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
//
// Contents:
//   sup_state_t    - supervisor FSM state encoding
//   TIMEOUT_MULT   - timeout limit is TIMEOUT_MULT * DIV_EXPECT clk cycles
//   timeout_limit  - evaluates the timeout limit for a given DIV_EXPECT
//   period_width   - width of the period counter / period output
package pll_sup_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        CHECK_ARM = 3'd2,
        CHECK     = 3'd3,
        RUN       = 3'd4
    } sup_state_t;

    // A clkoutd period longer than four nominal periods is treated as a
    // stalled divider rather than a slow one.
    localparam int TIMEOUT_MULT = 4;

    function automatic int timeout_limit(input int div_expect);
        return TIMEOUT_MULT * div_expect;
    endfunction

    // Wide enough to hold the saturated counter plus one (the value loaded
    // into the period register when a tick lands on a saturated counter).
    function automatic int period_width(input int div_expect);
        return $clog2(TIMEOUT_MULT * div_expect + 1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_edge.sv
// Purpose : multi-flop synchronizer with a registered rising-edge pulse.
// Latency : d_sync trails d_in by SYNC_STAGES cycles; rise by SYNC_STAGES+1.
// Backpr. : none; free-running, samples every clk.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   d_in      - asynchronous level input
//   d_sync    - synchronized level
//   rise      - one-cycle pulse on each 0->1 transition of d_sync
module sync_edge #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_sr;
    logic                   d_prev;

    // sync_sr[0] is the metastability-catching flop; only the last stage is
    // ever looked at by downstream logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sr <= '0;
            d_prev  <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], d_in};
            d_prev  <= sync_sr[SYNC_STAGES-1];
            rise    <= sync_sr[SYNC_STAGES-1] & ~d_prev;
        end
    end

    assign d_sync = sync_sr[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Purpose : qualifies PLL lock and clkoutd period, gates downstream reset,
//           and converts clkoutd into a single-cycle enable tick.
// Latency : tick SYNC_STAGES+1 cycles after clkoutd rises; sys_rst asserts
//           SYNC_STAGES+1 cycles after pll_lock falls.
// Backpr. : none; all inputs are sampled every clk, outputs are levels/pulses.
//
// Ports:
//   clk       - PLL clkout, the only clock
//   rst       - synchronous active-high reset
//   pll_lock  - PLL lock, asynchronous to clk
//   clkoutd   - PLL divided output, sampled as data
//   sys_rst   - downstream synchronous active-high reset, low only in RUN
//   ready     - high only in RUN
//   tick      - one-cycle pulse per clkoutd rising edge (all states)
//   freq_err  - sticky period/timeout error, cleared only by rst
//   loss_cnt  - saturating count of lock losses out of RUN
//   period    - last measured clkoutd period in clk cycles
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int DIV_EXPECT    = 100,
    parameter int DIV_TOL       = 2,
    parameter int CNT_W         = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pll_lock,
    input  logic                                clkoutd,
    output logic                                sys_rst,
    output logic                                ready,
    output logic                                tick,
    output logic                                freq_err,
    output logic [CNT_W-1:0]                    loss_cnt,
    output logic [period_width(DIV_EXPECT)-1:0] period
);

    localparam int PW    = period_width(DIV_EXPECT);
    localparam int LIMIT = timeout_limit(DIV_EXPECT);
    localparam int STW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [PW-1:0]  LIMIT_P   = PW'(LIMIT);
    localparam logic [PW-1:0]  PER_MIN   = PW'(DIV_EXPECT - DIV_TOL);
    localparam logic [PW-1:0]  PER_MAX   = PW'(DIV_EXPECT + DIV_TOL);
    localparam logic [STW-1:0] STAB_LAST = STW'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic lock_s;
    logic d_s;
    logic unused_lock_rise;   // only the lock level matters

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_lock (
        .clk    (clk),
        .rst    (rst),
        .d_in   (pll_lock),
        .d_sync (lock_s),
        .rise   (unused_lock_rise)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_clkd (
        .clk    (clk),
        .rst    (rst),
        .d_in   (clkoutd),
        .d_sync (d_s),
        .rise   (tick)
    );

    // ------------------------------------------------------------------
    // Period measurement
    // ------------------------------------------------------------------
    // per_cnt counts cycles since the last tick; the measured period is
    // per_cnt+1 because the tick cycle itself belongs to the period.
    logic [PW-1:0] per_cnt;
    logic [PW-1:0] per_meas;
    logic          timeout;
    logic          in_range;

    assign per_meas = per_cnt + PW'(1);

    // A tick on the same cycle as a saturated counter wins: it is a real
    // edge and gets evaluated (as an out-of-range period) instead.
    assign timeout  = (per_cnt == LIMIT_P) && !tick;
    assign in_range = (per_meas >= PER_MIN) && (per_meas <= PER_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
            period  <= '0;
        end else if (tick) begin
            period  <= per_meas;
            per_cnt <= '0;
        end else if (per_cnt != LIMIT_P) begin
            per_cnt <= per_meas;
        end
    end

    // ------------------------------------------------------------------
    // Supervisor FSM
    // ------------------------------------------------------------------
    // sys_rst/ready are only ever released on the RUN-entry transition and
    // re-asserted on the RUN-exit transition, so they cannot drop outside
    // RUN. Lock loss is tested first in every state so it outranks both
    // period evaluation and timeout.
    sup_state_t     state;
    logic [STW-1:0] stab_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
            freq_err <= 1'b0;
            loss_cnt <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state    <= STABLE;
                        stab_cnt <= '0;
                    end
                end

                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (stab_cnt == STAB_LAST) begin
                        state <= CHECK_ARM;
                    end else begin
                        stab_cnt <= stab_cnt + STW'(1);
                    end
                end

                // The first tick here only aligns the measurement; the
                // partial period before it is meaningless.
                CHECK_ARM: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (tick) begin
                        state <= CHECK;
                    end else if (timeout) begin
                        freq_err <= 1'b1;
                    end
                end

                // An out-of-range period keeps measuring from this tick,
                // since the period counter already restarted on it.
                CHECK: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (tick) begin
                        if (in_range) begin
                            state   <= RUN;
                            sys_rst <= 1'b0;
                            ready   <= 1'b1;
                        end else begin
                            freq_err <= 1'b1;
                        end
                    end else if (timeout) begin
                        freq_err <= 1'b1;
                        state    <= CHECK_ARM;
                    end
                end

                // Frequency faults in RUN are reported but do not revoke
                // the downstream reset; only lock loss does.
                RUN: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                        if (loss_cnt != {CNT_W{1'b1}}) begin
                            loss_cnt <= loss_cnt + CNT_W'(1);
                        end
                    end else if (tick) begin
                        if (!in_range) begin
                            freq_err <= 1'b1;
                        end
                    end else if (timeout) begin
                        freq_err <= 1'b1;
                    end
                end

                default: begin
                    state   <= WAIT_LOCK;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose : directed self-checking bench for pll_lock_supervisor.
// Latency : n/a.
// Backpr. : n/a.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       clkoutd;
    logic       sys_rst;
    logic       ready;
    logic       tick;
    logic       freq_err;
    logic [7:0] loss_cnt;
    logic [8:0] period;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_cnt = 0;
    int div_per  = 0;     // clkoutd period in clk cycles, 0 = held low
    int gen_hi;
    int gen_lo;

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16),
        .DIV_EXPECT    (100),
        .DIV_TOL       (2),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .clkoutd  (clkoutd),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .tick     (tick),
        .freq_err (freq_err),
        .loss_cnt (loss_cnt),
        .period   (period)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (tick === 1'b1) tick_cnt = tick_cnt + 1;
    end

    // clkoutd model: square wave of div_per clk cycles, re-read every half.
    initial begin
        clkoutd = 1'b0;
        forever begin
            if (div_per == 0) begin
                clkoutd = 1'b0;
                @(posedge clk); #1;
            end else begin
                gen_hi = div_per / 2;
                gen_lo = div_per - gen_hi;
                clkoutd = 1'b1;
                repeat (gen_hi) begin @(posedge clk); #1; end
                clkoutd = 1'b0;
                repeat (gen_lo) begin @(posedge clk); #1; end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (ready !== 1'b1 && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int t0;
        int loss_at_100;
        logic relock_ok;

        rst      = 1'b1;
        pll_lock = 1'b0;
        div_per  = 0;

        // ---- reset values ----
        do_reset(4);
        check("rst_sys_rst",  32'(sys_rst),  32'd1);
        check("rst_ready",    32'(ready),    32'd0);
        check("rst_tick",     32'(tick),     32'd0);
        check("rst_freq_err", 32'(freq_err), 32'd0);
        check("rst_loss_cnt", 32'(loss_cnt), 32'd0);
        check("rst_period",   32'(period),   32'd0);

        // ---- clkoutd stuck low: timeout reported on CHECK_ARM entry ----
        // 2 sync + 1 enter STABLE + 16 stable + 1 in CHECK_ARM = 20 cycles.
        repeat (420) step();
        t0 = tick_cnt;
        pll_lock = 1'b1;
        n = 0;
        while (freq_err !== 1'b1 && n < 200) begin step(); n++; end
        check("stuck_err_latency", 32'(n),        32'd20);
        check("stuck_sys_rst",     32'(sys_rst),  32'd1);
        check("stuck_ready",       32'(ready),    32'd0);
        check("stuck_no_tick",     32'(tick_cnt - t0), 32'd0);
        check("stuck_loss_cnt",    32'(loss_cnt), 32'd0);

        // ---- one-cycle lock drop 8 cycles into STABLE restarts stability ----
        // lock_s re-rises at cycle 14, so the error appears 18 later: 32.
        pll_lock = 1'b0;
        do_reset(4);
        repeat (420) step();
        pll_lock = 1'b1;
        n = 0;
        repeat (11) begin step(); n++; end
        pll_lock = 1'b0;
        step(); n++;
        pll_lock = 1'b1;
        while (freq_err !== 1'b1 && n < 200) begin step(); n++; end
        check("glitch_err_latency", 32'(n),        32'd32);
        check("glitch_loss_cnt",    32'(loss_cnt), 32'd0);

        // ---- nominal bring-up with period 100 ----
        pll_lock = 1'b0;
        div_per  = 100;
        do_reset(4);
        repeat (6) step();
        pll_lock = 1'b1;
        wait_ready(600, n);
        check("boot_ready_window", 32'((n >= 120) && (n <= 225)), 32'd1);
        check("boot_sys_rst",      32'(sys_rst),  32'd0);
        check("boot_freq_err",     32'(freq_err), 32'd0);
        check("boot_period",       32'(period),   32'd100);
        check("boot_loss_cnt",     32'(loss_cnt), 32'd0);
        t0 = tick_cnt;
        repeat (500) step();
        check("run_tick_count",    32'(tick_cnt - t0), 32'd5);
        check("run_ready_held",    32'(ready),    32'd1);

        // ---- lock loss in RUN: reset reasserts after SYNC_STAGES+1 ----
        pll_lock = 1'b0;
        step(); step();
        check("loss_c2_sys_rst", 32'(sys_rst),  32'd0);
        step();
        check("loss_c3_sys_rst", 32'(sys_rst),  32'd1);
        check("loss_c3_ready",   32'(ready),    32'd0);
        check("loss_cnt_one",    32'(loss_cnt), 32'd1);
        pll_lock = 1'b1;
        wait_ready(600, n);
        check("relock_ready",    32'(ready),    32'd1);
        check("relock_sys_rst",  32'(sys_rst),  32'd0);
        check("relock_loss_cnt", 32'(loss_cnt), 32'd1);

        // ---- period 110 out of range, then 102 in range ----
        pll_lock = 1'b0;
        div_per  = 110;
        do_reset(4);
        pll_lock = 1'b1;
        repeat (400) step();
        check("p110_freq_err", 32'(freq_err), 32'd1);
        check("p110_period",   32'(period),   32'd110);
        check("p110_sys_rst",  32'(sys_rst),  32'd1);
        check("p110_ready",    32'(ready),    32'd0);
        div_per = 102;
        wait_ready(800, n);
        check("p102_ready",    32'(ready),    32'd1);
        check("p102_period",   32'(period),   32'd102);
        check("p102_freq_err", 32'(freq_err), 32'd1);

        // ---- 300 lock losses from RUN: loss_cnt saturates at 255 ----
        pll_lock  = 1'b0;
        div_per   = 98;
        do_reset(4);
        pll_lock  = 1'b1;
        relock_ok = 1'b1;
        loss_at_100 = 0;
        for (int i = 0; i < 300; i++) begin
            wait_ready(600, n);
            if (ready !== 1'b1) begin
                relock_ok = 1'b0;
                break;
            end
            pll_lock = 1'b0;
            step();
            pll_lock = 1'b1;
            step();
            step();
            if (i == 99) loss_at_100 = int'(loss_cnt);
        end
        check("sat_relock_ok",   32'(relock_ok),   32'd1);
        check("sat_loss_at_100", 32'(loss_at_100), 32'd100);
        check("sat_loss_cnt",    32'(loss_cnt),    32'd255);

        // ---- rst mid-RUN restores every output next cycle ----
        wait_ready(600, n);
        check("mid_run_ready", 32'(ready), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_sys_rst",  32'(sys_rst),  32'd1);
        check("mid_rst_ready",    32'(ready),    32'd0);
        check("mid_rst_tick",     32'(tick),     32'd0);
        check("mid_rst_freq_err", 32'(freq_err), 32'd0);
        check("mid_rst_loss_cnt", 32'(loss_cnt), 32'd0);
        check("mid_rst_period",   32'(period),   32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
